// File: rtl/tdm_splitter_pkg.sv
// Shared constants and helpers for the TDM slot splitter.
package splitter_pkg;

  localparam int N_DEF   = 4;
  localparam int W_DEF   = 8;
  localparam int LW_DEF  = 8;
  localparam int DIV_DEF = 1;

  // Slot lengths of the fixed four-channel splitter this block replaces
  localparam int SLOT0_LEN = 142;
  localparam int SLOT1_LEN = 109;
  localparam int SLOT2_LEN = 76;
  localparam int SLOT3_LEN = 43;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/tdm_splitter_if.sv
// Control/data bundle between the channel sources, the splitter and the DAC side.
interface tdm_splitter_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int LW = 8
);
  import splitter_pkg::*;

  localparam int CW = clog2(N);

  logic            run;
  logic [N-1:0]    chanEn;
  logic [N*W-1:0]  chanData;
  logic [N*LW-1:0] slotLen;
  logic [W-1:0]    currentData;
  logic [LW-1:0]   count;
  logic [CW-1:0]   chan;
  logic            sampleValid;
  logic            frameStart;

  modport master (
    output run, chanEn, chanData, slotLen,
    input  currentData, count, chan, sampleValid, frameStart
  );

  modport slave (
    input  run, chanEn, chanData, slotLen,
    output currentData, count, chan, sampleValid, frameStart
  );

endinterface

// File: rtl/tdm_splitter_tick_divider.sv
// Sample-tick generator: one tick every DIV clocks while run is high.
module tick_divider
  import splitter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int DW = (DIV > 1) ? clog2(DIV) : 1;

  logic [DW-1:0] div;

  assign tick = run && (div == DW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div <= '0;
    else if (!run || tick)
      div <= '0;
    else
      div <= div + DW'(1);
  end

endmodule

// File: rtl/tdm_splitter.sv
// Parametrised TDM slot sequencer/mux with shadowed slot lengths.
// Optional SPLITTER_SKIP_EN: disabled channels are skipped and consume no ticks.
module tdm_splitter
  import splitter_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int W   = W_DEF,
  parameter int LW  = LW_DEF,
  parameter int DIV = DIV_DEF
) (
  input  logic          clk,
  input  logic          rst,
  tdm_splitter_if.slave bus
);

  localparam int CW = clog2(N);

  logic          tick;
  logic [CW-1:0] ch, cur, nxt;
  logic [LW-1:0] cnt, len_eff;
  logic [LW-1:0] len_shadow [N];
  logic          frame_pend, fs, last, wrap;

  tick_divider #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .run  (bus.run),
    .tick (tick)
  );

`ifdef SPLITTER_SKIP_EN
  // First enabled channel at or after start, circularly; 0 when none is enabled
  function automatic logic [CW-1:0] first_en(input logic [N-1:0] en, input int start);
    logic [CW-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int j;
      j = (start + i) % N;
      if (en[j]) r = CW'(j);
    end
    return r;
  endfunction
`endif

  always_comb begin
    fs = frame_pend && (cnt == '0);
`ifdef SPLITTER_SKIP_EN
    cur = fs ? first_en(bus.chanEn, int'(ch)) : ch;
    nxt = first_en(bus.chanEn, (int'(cur) + 1) % N);
`else
    cur = ch;
    nxt = (cur == CW'(N - 1)) ? '0 : cur + CW'(1);
`endif
    // The frame-start tick already uses the lengths being captured on it
    len_eff = fs ? bus.slotLen[int'(cur)*LW +: LW] : len_shadow[cur];
    last    = (cnt == len_eff);
    wrap    = last && (nxt <= cur);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch              <= '0;
      cnt             <= '0;
      frame_pend      <= 1'b1;
      bus.currentData <= '0;
      bus.count       <= '0;
      bus.chan        <= '0;
      bus.sampleValid <= 1'b0;
      bus.frameStart  <= 1'b0;
      for (int k = 0; k < N; k++) len_shadow[k] <= '0;
    end else if (!bus.run) begin
      ch              <= '0;
      cnt             <= '0;
      frame_pend      <= 1'b1;
      bus.currentData <= '0;
      bus.count       <= '0;
      bus.chan        <= '0;
      bus.sampleValid <= 1'b0;
      bus.frameStart  <= 1'b0;
      for (int k = 0; k < N; k++) len_shadow[k] <= '0;
    end else if (tick) begin
      bus.currentData <= bus.chanEn[cur] ? bus.chanData[int'(cur)*W +: W] : '0;
      bus.count       <= cnt;
      bus.chan        <= cur;
      bus.sampleValid <= 1'b1;
      bus.frameStart  <= fs;
      if (fs)
        for (int k = 0; k < N; k++) len_shadow[k] <= bus.slotLen[k*LW +: LW];
      if (last) begin
        cnt <= '0;
        ch  <= nxt;
      end else begin
        cnt <= cnt + LW'(1);
        ch  <= cur;
      end
      frame_pend <= wrap;
    end else begin
      bus.sampleValid <= 1'b0;
      bus.frameStart  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_splitter.sv
// Directed bench for tdm_splitter: DIV=1 instance for timing/gating/shadowing, DIV=13 for divider/reset.
module tb_tdm_splitter;
  import splitter_pkg::*;

  logic clk = 1'b0;
  logic rst, rst13;
  always #5 clk = ~clk;

  tdm_splitter_if #(.N(4), .W(8), .LW(8)) bus_a ();
  tdm_splitter_if #(.N(4), .W(8), .LW(8)) bus_b ();

  tdm_splitter #(.N(4), .W(8), .LW(8), .DIV(1))  dut_a (.clk(clk), .rst(rst),   .bus(bus_a.slave));
  tdm_splitter #(.N(4), .W(8), .LW(8), .DIV(13)) dut_b (.clk(clk), .rst(rst13), .bus(bus_b.slave));

  localparam logic [31:0] LEN_LEGACY = {8'd43, 8'd76, 8'd109, 8'd142};
  localparam logic [31:0] DATA_ALL   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] cd [1000];
  logic [7:0] cc [1000];
  logic [1:0] cch[1000];
  logic       cfs[1000];
  int         ncap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Record n consecutive samples of DUT A, one per clock, starting at the first valid
  task automatic capture(input int n, input int mod_at, input logic [31:0] mod_len);
    int waitc, missing;
    waitc = 0;
    missing = 0;
    while (!bus_a.sampleValid && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("first_valid_seen", {31'd0, bus_a.sampleValid}, 1);
    for (int i = 0; i < n; i++) begin
      if (i == mod_at) bus_a.slotLen = mod_len;
      cd[i]  = bus_a.currentData;
      cc[i]  = bus_a.count;
      cch[i] = bus_a.chan;
      cfs[i] = bus_a.frameStart;
      if (!bus_a.sampleValid) missing++;
      @(negedge clk);
    end
    ncap = n;
    check("valid_every_clk", missing, 0);
  endtask

  task automatic restart();
    bus_a.run = 1'b0;
    @(negedge clk);
    bus_a.run = 1'b1;
  endtask

  function automatic int run_start(input int r);
    int p;
    p = 0;
    for (int k = 0; k < r; k++) begin
      logic [7:0] v;
      v = cd[p];
      while (p < ncap && cd[p] == v) p++;
    end
    return p;
  endfunction

  function automatic int run_len(input int r);
    return run_start(r + 1) - run_start(r);
  endfunction

  function automatic int count_fs();
    int c;
    c = 0;
    for (int i = 0; i < ncap; i++) if (cfs[i]) c++;
    return c;
  endfunction

  function automatic int max_cnt(input int c, input int lo, input int hi);
    int m;
    m = -1;
    for (int i = lo; i < hi; i++) if (cch[i] == c[1:0] && int'(cc[i]) > m) m = int'(cc[i]);
    return m;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int found;
    rst   = 1'b1;
    rst13 = 1'b1;
    bus_a.run = 1'b0;        bus_b.run = 1'b0;
    bus_a.chanEn = 4'hF;     bus_b.chanEn = 4'hF;
    bus_a.chanData = DATA_ALL; bus_b.chanData = DATA_ALL;
    bus_a.slotLen = LEN_LEGACY; bus_b.slotLen = LEN_LEGACY;
    repeat (2) @(negedge clk);

    check("reset_data",  {24'd0, bus_a.currentData}, 0);
    check("reset_ctrl",  {20'd0, bus_a.count, bus_a.chan, bus_a.sampleValid, bus_a.frameStart}, 0);

    // Legacy timing
    rst = 1'b0;
    @(negedge clk);
    bus_a.run = 1'b1;
    capture(748, -1, 32'd0);
    check("leg_run0_len", run_len(0), 143);
    check("leg_run0_val", {24'd0, cd[0]}, 32'hA0);
    check("leg_run1_len", run_len(1), 110);
    check("leg_run1_val", {24'd0, cd[run_start(1)]}, 32'hB1);
    check("leg_run2_len", run_len(2), 77);
    check("leg_run3_len", run_len(3), 44);
    check("leg_run3_val", {24'd0, cd[run_start(3)]}, 32'hD3);
    check("leg_run4_len", run_len(4), 143);
    check("leg_fs_first", {31'd0, cfs[0]}, 1);
    check("leg_fs_374",   {31'd0, cfs[374]}, 1);
    check("leg_fs_count", count_fs(), 2);
    check("leg_max_c0", max_cnt(0, 0, 374), 142);
    check("leg_max_c1", max_cnt(1, 0, 374), 109);
    check("leg_max_c2", max_cnt(2, 0, 374), 76);
    check("leg_max_c3", max_cnt(3, 0, 374), 43);
    check("leg_boundary", {22'd0, cch[143], cc[143]}, {22'd0, 2'd1, 8'd0});

    // Synchronous clear mid-frame
    repeat (200) @(negedge clk);
    bus_a.run = 1'b0;
    @(negedge clk);
    check("clr_outputs", {13'd0, bus_a.currentData, bus_a.count, bus_a.chan, bus_a.sampleValid, bus_a.frameStart}, 0);
    bus_a.run = 1'b1;
    @(negedge clk);
    check("clr_restart", {13'd0, bus_a.currentData, bus_a.count, bus_a.chan, bus_a.sampleValid, bus_a.frameStart},
          {13'd0, 8'hA0, 8'd0, 2'd0, 1'b1, 1'b1});
    @(negedge clk);
    check("clr_second",  {22'd0, bus_a.count, bus_a.frameStart}, {22'd0, 8'd1, 1'b0});

`ifndef SPLITTER_SKIP_EN
    // Gating without skipping
    bus_a.chanEn = 4'b1010;
    restart();
    capture(748, -1, 32'd0);
    check("gate_run0_len", run_len(0), 143);
    check("gate_run0_val", {24'd0, cd[0]}, 0);
    check("gate_run1_len", run_len(1), 110);
    check("gate_run1_val", {24'd0, cd[run_start(1)]}, 32'hB1);
    check("gate_run2_len", run_len(2), 77);
    check("gate_run2_val", {24'd0, cd[run_start(2)]}, 0);
    check("gate_run3_val", {24'd0, cd[run_start(3)]}, 32'hD3);
    check("gate_fs_374",   {31'd0, cfs[374]}, 1);
    check("gate_fs_count", count_fs(), 2);
    bus_a.chanEn = 4'hF;
`endif

    // Shadow lengths: ch0 shortened to 9 while in ch1
    restart();
    capture(640, 200, {8'd43, 8'd76, 8'd109, 8'd9});
    check("shd_run0_len", run_len(0), 143);
    check("shd_run3_len", run_len(3), 44);
    check("shd_run4_len", run_len(4), 10);
    check("shd_run5_len", run_len(5), 110);
    check("shd_fs_374",   {31'd0, cfs[374]}, 1);
    check("shd_fs_615",   {31'd0, cfs[615]}, 1);
    check("shd_fs_count", count_fs(), 3);

    // One-tick slot on ch1
    bus_a.slotLen = {8'd43, 8'd76, 8'd0, 8'd9};
    restart();
    capture(200, -1, 32'd0);
    check("one_run0_len", run_len(0), 10);
    check("one_run1_len", run_len(1), 1);
    check("one_run1_val", {24'd0, cd[10]}, 32'hB1);
    check("one_run2_len", run_len(2), 77);
    check("one_fs_132",   {31'd0, cfs[132]}, 1);

`ifdef SPLITTER_SKIP_EN
    bus_a.chanEn = 4'b0100;
    restart();
    capture(200, -1, 32'd0);
    k = 0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (cd[i] != 8'hC2) k++;
      if (cch[i] != 2'd2) found++;
    end
    check("skip_only_c2",   k, 0);
    check("skip_chan2",     found, 0);
    check("skip_fs_77",     {31'd0, cfs[77]}, 1);
    check("skip_fs_count",  count_fs(), 3);

    bus_a.chanEn = 4'b0000;
    restart();
    capture(100, -1, 32'd0);
    k = 0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (cd[i] != 8'h00) k++;
      if (cch[i] != 2'd0) found++;
    end
    check("none_zero_data", k, 0);
    check("none_chan0",     found, 0);
    check("none_fs_count",  count_fs(), 10);
    bus_a.chanEn = 4'hF;
`endif

    // Divider and asynchronous reset on the DIV=13 instance
    rst13 = 1'b0;
    @(negedge clk);
    bus_b.run = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus_b.sampleValid && k < 40);
    check("div_first_tick", k, 13);
    check("div_first_data", {23'd0, bus_b.currentData, bus_b.frameStart}, {23'd0, 8'hA0, 1'b1});
    k = 0;
    do begin @(negedge clk); k++; end while (!bus_b.sampleValid && k < 40);
    check("div_period", k, 13);
    found = 0;
    for (int i = 0; i < 5000 && found == 0; i++) begin
      @(negedge clk);
      if (bus_b.sampleValid && bus_b.chan == 2'd2 && bus_b.count == 8'd40) found = 1;
    end
    check("div_reach_c2_40", found, 1);
    #2 rst13 = 1'b1;
    #1;
    check("arst_outputs", {13'd0, bus_b.currentData, bus_b.count, bus_b.chan, bus_b.sampleValid, bus_b.frameStart}, 0);
    @(negedge clk);
    rst13 = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus_b.sampleValid && k < 40);
    check("arst_first_tick", k, 13);
    check("arst_first_smp", {21'd0, bus_b.currentData, bus_b.chan, bus_b.frameStart}, {21'd0, 8'hA0, 2'd0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
